// File: rtl/interp_out_stage_pkg.sv
// Shared constants and helpers for the interpolator output stage.
// Widths derive from the sample/coefficient sizes so every file agrees on Q-formats.
package interp_out_stage_pkg;

    localparam int SAMPLE_SIZE_DEF = 16;
    localparam int COEFF_SIZE_DEF  = 16;
    localparam int FIFO_DEPTH_DEF  = 4;

    // Accumulator width: product of a Q1.(S-1) sample and a Q1.(C-1) coefficient.
    function automatic int acc_w(input int ss, input int cs);
        return ss + cs;
    endfunction

    // Half an output LSB at accumulator scale, for round-half-up.
    function automatic int rnd_ofs(input int ss);
        return 1 << (ss - 2);
    endfunction

    // Right shift that takes Q2.(ACC_W-2) down to Q1.(SAMPLE_SIZE-1).
    function automatic int q_shift(input int ss);
        return ss - 1;
    endfunction

    function automatic logic [31:0] sat_max(input int ss);
        return (32'd1 << (ss - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_min(input int ss);
        return 32'd1 << (ss - 1);
    endfunction

endpackage

// File: rtl/interp_out_stage_fifo.sv
// First-word-fall-through output buffer; reports writes dropped while full.
// A pop and a write in the same cycle are both honoured, except on an empty buffer (no bypass).
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             pop, push, full;

    always_comb begin
        pop      = rd_en && (count_q != '0);
        full     = (count_q == (AW+1)'(DEPTH));
        push     = wr_en && (!full || pop);
        drop     = wr_en && full && !pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = (count_q != '0);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/interp_out_stage.sv
// Turns two free-running MAC accumulators into rounded, saturated output samples.
// Stage 1 differences the accumulators, stage 2 rounds/clamps, stage 3 buffers in the FIFO.
module interp_out_stage
    import interp_out_stage_pkg::*;
#(
    parameter int  SAMPLE_SIZE = SAMPLE_SIZE_DEF,
    parameter int  COEFF_SIZE  = COEFF_SIZE_DEF,
    parameter int  FIFO_DEPTH  = FIFO_DEPTH_DEF,
    localparam int ACC_W       = acc_w(SAMPLE_SIZE, COEFF_SIZE)
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [ACC_W-1:0]       acc_a,
    input  logic [ACC_W-1:0]       acc_b,
    input  logic                   snap,
    output logic [SAMPLE_SIZE-1:0] dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   sat,
    output logic                   ovf,
    input  logic                   clr_flags
);
    // Two guard bits: one for the a+b sum, one for the rounding offset on top of it.
    localparam int SUM_W = ACC_W + 2;
    localparam int SH    = q_shift(SAMPLE_SIZE);
    localparam int RES_W = SUM_W - SH;
    localparam logic [SAMPLE_SIZE-1:0] SAT_MAX = SAMPLE_SIZE'(sat_max(SAMPLE_SIZE));
    localparam logic [SAMPLE_SIZE-1:0] SAT_MIN = SAMPLE_SIZE'(sat_min(SAMPLE_SIZE));

    logic [ACC_W-1:0]         prev_a_q, prev_a_d, prev_b_q, prev_b_d;
    logic [ACC_W-1:0]         d_a_q, d_a_d, d_b_q, d_b_d;
    logic                     v1_q, v1_d, v2_q, v2_d;
    logic [SAMPLE_SIZE-1:0]   samp_q, samp_d;
    logic                     sat_q, sat_d, ovf_q, ovf_d;
    logic signed [SUM_W-1:0]  sum;
    logic signed [RES_W-1:0]  res;
    logic [RES_W-SAMPLE_SIZE:0] upper;
    logic                     sat_evt, drop;

    always_comb begin
        prev_a_d = prev_a_q;
        prev_b_d = prev_b_q;
        d_a_d    = d_a_q;
        d_b_d    = d_b_q;
        v1_d     = snap;
        // Modular subtraction absorbs upstream accumulator wrap-around.
        if (snap) begin
            d_a_d    = acc_a - prev_a_q;
            d_b_d    = acc_b - prev_b_q;
            prev_a_d = acc_a;
            prev_b_d = acc_b;
        end

        sum = $signed({{2{d_a_q[ACC_W-1]}}, d_a_q})
            + $signed({{2{d_b_q[ACC_W-1]}}, d_b_q})
            + $signed(SUM_W'(rnd_ofs(SAMPLE_SIZE)));
        res   = RES_W'(sum >>> SH);
        upper = res[RES_W-1:SAMPLE_SIZE-1];

        v2_d    = v1_q;
        samp_d  = samp_q;
        sat_evt = 1'b0;
        if (v1_q) begin
            // In range only when every bit above the sample MSB copies the sign.
            if ((&upper) || !(|upper)) begin
                samp_d = res[SAMPLE_SIZE-1:0];
            end else begin
                samp_d  = res[RES_W-1] ? SAT_MIN : SAT_MAX;
                sat_evt = 1'b1;
            end
        end

        sat_d = (sat_q && !clr_flags) || sat_evt;
        ovf_d = (ovf_q && !clr_flags) || drop;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prev_a_q <= '0;
            prev_b_q <= '0;
            d_a_q    <= '0;
            d_b_q    <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            samp_q   <= '0;
            sat_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            prev_a_q <= prev_a_d;
            prev_b_q <= prev_b_d;
            d_a_q    <= d_a_d;
            d_b_q    <= d_b_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            samp_q   <= samp_d;
            sat_q    <= sat_d;
            ovf_q    <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (SAMPLE_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .nrst     (nrst),
        .wr_en    (v2_q),
        .wr_data  (samp_q),
        .rd_en    (dout_ready),
        .rd_data  (dout),
        .rd_valid (dout_valid),
        .drop     (drop)
    );

    assign sat = sat_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_interp_out_stage.sv
// Randomised bench for interp_out_stage: arithmetic reference model plus a queue-based
// scoreboard that follows each sample through the output buffer.
module tb_interp_out_stage;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        snap = 1'b0;
    logic        dout_ready = 1'b0;
    logic        clr_flags = 1'b0;
    logic [31:0] acc_a = '0;
    logic [31:0] acc_b = '0;
    logic [15:0] dout;
    logic        dout_valid, sat, ovf;

    always #5 clk = ~clk;

    interp_out_stage #(
        .SAMPLE_SIZE (16),
        .COEFF_SIZE  (16),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .acc_a      (acc_a),
        .acc_b      (acc_b),
        .snap       (snap),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .sat        (sat),
        .ovf        (ovf),
        .clr_flags  (clr_flags)
    );

    typedef struct {
        logic [15:0] smp;
        bit          st;
        int          due;
    } pend_t;

    pend_t       pipe_q[$];
    logic [15:0] fifo_m[$];
    bit          exp_sat, exp_ovf;
    int          cyc, nvec, nerr;
    logic [31:0] prev_a_m, prev_b_m;

    // Reference arithmetic straight from the Q-format rules: wrap-difference, sum, round, clamp.
    task automatic model_snap(input logic [31:0] a, input logic [31:0] b,
                              output logic [15:0] s, output bit st);
        logic signed [31:0] da, db;
        longint sum, r;
        da = a - prev_a_m;
        db = b - prev_b_m;
        sum = longint'(da) + longint'(db);
        r = (sum + 64'sd16384) >>> 15;
        st = 1'b0;
        if (r > 64'sd32767) begin
            s = 16'h7FFF; st = 1'b1;
        end else if (r < -64'sd32768) begin
            s = 16'h8000; st = 1'b1;
        end else begin
            s = 16'(r);
        end
        prev_a_m = a;
        prev_b_m = b;
    endtask

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Model of the output buffer, advanced on every rising edge.
    bit    m_pop, m_sev, m_oev;
    pend_t m_e;
    always @(posedge clk) begin
        cyc++;
        if (!nrst) begin
            pipe_q.delete();
            fifo_m.delete();
            exp_sat = 1'b0;
            exp_ovf = 1'b0;
        end else begin
            m_sev = 1'b0;
            m_oev = 1'b0;
            m_pop = dout_ready && (fifo_m.size() > 0);
            if (m_pop) begin
                $display("cycle %0d: consumer takes sample %h", cyc, fifo_m[0]);
                void'(fifo_m.pop_front());
            end
            foreach (pipe_q[i]) begin
                if (pipe_q[i].due - 1 == cyc && pipe_q[i].st) m_sev = 1'b1;
            end
            if (pipe_q.size() > 0 && pipe_q[0].due == cyc) begin
                m_e = pipe_q.pop_front();
                if (fifo_m.size() < DEPTH) fifo_m.push_back(m_e.smp);
                else m_oev = 1'b1;
            end
            exp_sat = (exp_sat && !clr_flags) || m_sev;
            exp_ovf = (exp_ovf && !clr_flags) || m_oev;
        end
    end

    // Monitor: compare DUT outputs against the scoreboard head on every falling edge.
    always @(negedge clk) begin
        if (!nrst) begin
            chk("rst_valid", {31'd0, dout_valid}, 32'd0);
            chk("rst_dout", {16'd0, dout}, 32'd0);
            chk("rst_flags", {30'd0, sat, ovf}, 32'd0);
        end else begin
            chk("dout_valid", {31'd0, dout_valid}, {31'd0, fifo_m.size() > 0});
            if (fifo_m.size() > 0) chk("dout", {16'd0, dout}, {16'd0, fifo_m[0]});
            chk("sat", {31'd0, sat}, {31'd0, exp_sat});
            chk("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
        end
    end

    task automatic step(input bit sn, input logic [31:0] a, input logic [31:0] b,
                        input bit rdy, input bit clr);
        logic [15:0] s;
        bit          st;
        @(negedge clk);
        snap = sn; acc_a = a; acc_b = b; dout_ready = rdy; clr_flags = clr;
        if (sn) begin
            model_snap(a, b, s, st);
            pipe_q.push_back('{smp: s, st: st, due: cyc + 3});
            $display("cycle %0d: snap a=%h b=%h -> expect %h sat=%0d", cyc, a, b, s, st);
        end
    endtask

    task automatic snapd(input logic [31:0] da, input logic [31:0] db, input bit rdy);
        step(1'b1, prev_a_m + da, prev_b_m + db, rdy, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, acc_a, acc_b, rdy, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        snap = 1'b0;
        @(posedge clk); #2 nrst = 1'b0;
        @(posedge clk); #2 nrst = 1'b1;
        prev_a_m = '0;
        prev_b_m = '0;
    endtask

    initial begin
        prev_a_m = '0;
        prev_b_m = '0;
        #1 nrst = 1'b0;
        repeat (2) @(posedge clk);
        #2 nrst = 1'b1;

        // Basic samples from reset, then a second snap on a moving base.
        step(1'b1, 32'h2000_0000, 32'h0, 1'b0, 1'b0);
        idle(5, 1'b1);
        step(1'b1, 32'h3000_0000, 32'h1000_0000, 1'b1, 1'b0);
        idle(5, 1'b1);

        // Rounding boundaries.
        snapd(32'h0000_4000, 32'h0, 1'b1);
        snapd(32'h0000_3FFF, 32'h0, 1'b1);
        snapd(32'hFFFF_C000, 32'h0, 1'b1);
        idle(5, 1'b1);

        // Accumulator wrap-around, then positive saturation and a flag clear.
        step(1'b1, 32'hF000_0000, prev_b_m, 1'b1, 1'b0);
        step(1'b1, 32'h1000_0000, prev_b_m, 1'b1, 1'b0);
        idle(4, 1'b1);
        snapd(32'h4000_0000, 32'h4000_0000, 1'b1);
        idle(5, 1'b1);
        step(1'b0, acc_a, acc_b, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Five back-to-back samples into a stalled consumer, then drain.
        for (int k = 1; k <= 5; k++) snapd(32'(k) << 15, 32'h0, 1'b0);
        idle(6, 1'b0);
        idle(8, 1'b1);
        step(1'b0, acc_a, acc_b, 1'b1, 1'b1);

        // Reset with samples buffered; first snap afterwards differences against zero.
        for (int k = 1; k <= 3; k++) snapd(32'(k) << 15, 32'h0, 1'b0);
        idle(4, 1'b0);
        pulse_reset();
        step(1'b1, 32'h2000_0000, 32'h0, 1'b1, 1'b0);
        idle(5, 1'b1);

        // Random traffic: mostly small deltas, occasional full-range jumps.
        for (int n = 0; n < 600; n++) begin
            bit          sn, rdy, clr;
            logic [31:0] da, db;
            sn  = ($urandom_range(0, 9) < 6);
            rdy = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) begin
                da = $urandom();
                db = $urandom();
            end else begin
                da = 32'(int'($urandom_range(0, 2097152)) - 1048576);
                db = 32'(int'($urandom_range(0, 2097152)) - 1048576);
            end
            if (sn) step(1'b1, prev_a_m + da, prev_b_m + db, rdy, clr);
            else    step(1'b0, acc_a, acc_b, rdy, clr);
        end
        idle(12, 1'b1);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
